// File: rtl/sdu_pkg.sv
// Shared definitions for the serial debug unit dump path: ASCII constants,
// nibble-to-ASCII conversion and the dump FSM state encoding.
// Optional feature macro: SDU_DUMP_CKSUM_EN (adds the checksum state).
package sdu_pkg;

    localparam logic [7:0] ASCII_SP         = 8'h20;
    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;   // '0'
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;   // 'A'

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_HEX = 3'd1,
        ST_SEND_SEP = 3'd2,
`ifdef SDU_DUMP_CKSUM_EN
        ST_SEND_CK  = 3'd3,
`endif
        ST_SEND_CR  = 3'd4,
        ST_SEND_LF  = 3'd5,
        ST_FIN      = 3'd6
    } dump_state_e;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_DIGIT_BASE + {4'h0, n};
        end
        return ASCII_ALPHA_BASE + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter: baud counter plus 10-bit framer.
// ready_o is also asserted in the last clock of the stop bit so that a load
// on that edge starts the next start bit with no idle gap.
module uart_tx_byte #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);

    localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] baud_q;
    logic [3:0]       bit_q;
    logic [8:0]       shift_q;
    logic             active_q;
    logic             txd_q;

    assign ready_o = !active_q || ((bit_q == 4'd9) && (baud_q == CNT_LAST));
    assign txd_o   = txd_q;

    // Frame sequencing: load restarts the baud counter and drives the start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '1;
            active_q <= 1'b0;
            txd_q    <= 1'b1;
        end else if (load_i) begin
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= {1'b1, data_i};
            active_q <= 1'b1;
            txd_q    <= 1'b0;
        end else if (active_q) begin
            if (baud_q == CNT_LAST) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    bit_q    <= '0;
                    active_q <= 1'b0;
                    txd_q    <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    txd_q   <= shift_q[0];
                    shift_q <= {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_q <= baud_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sdu_dump_tx.sv
// Serial dump engine: snapshots NUM_CH channels on start and sends them as
// uppercase hex over UART, one space after each channel, then CR LF.
// Optional feature macro: SDU_DUMP_CKSUM_EN appends a two-digit mod-256
// sum of all bytes sent before CR LF.
module sdu_dump_tx
    import sdu_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int NUM_CH   = 8,
    parameter int DATA_W   = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     txd,
    output logic                     busy,
    output logic                     done
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int NIB   = DATA_W / 4;
    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int NIB_W = $clog2(NIB + 1);

    dump_state_e              state_q;
    logic [NUM_CH*DATA_W-1:0] snap_q;
    logic [CH_W-1:0]          ch_q;
    logic [NIB_W-1:0]         nib_q;
    logic                     busy_q;
    logic                     done_q;
`ifdef SDU_DUMP_CKSUM_EN
    logic [7:0]               sum_q;
`endif

    logic [DATA_W-1:0] word_sel;
    logic [3:0]        nib_sel;
    logic [7:0]        tx_byte_d;
    logic              tx_send;
    logic              tx_load;
    logic              tx_ready;

    assign busy    = busy_q;
    assign done    = done_q;
    assign tx_load = tx_send && tx_ready;

    // Pick the current channel word and its nibble, MSB nibble first.
    always_comb begin
        word_sel = '0;
        nib_sel  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) word_sel = snap_q[i*DATA_W +: DATA_W];
        end
        for (int j = 0; j < NIB; j++) begin
            if (nib_q == NIB_W'(j)) nib_sel = word_sel[(NIB-1-j)*4 +: 4];
        end
    end

    // Byte presented to the transmitter in each sending state.
    always_comb begin
        tx_byte_d = ASCII_SP;
        tx_send   = 1'b0;
        case (state_q)
            ST_SEND_HEX: begin
                tx_byte_d = nib2ascii(nib_sel);
                tx_send   = 1'b1;
            end
            ST_SEND_SEP: begin
                tx_byte_d = ASCII_SP;
                tx_send   = 1'b1;
            end
`ifdef SDU_DUMP_CKSUM_EN
            ST_SEND_CK: begin
                tx_byte_d = nib2ascii((nib_q == '0) ? sum_q[7:4] : sum_q[3:0]);
                tx_send   = 1'b1;
            end
`endif
            ST_SEND_CR: begin
                tx_byte_d = ASCII_CR;
                tx_send   = 1'b1;
            end
            ST_SEND_LF: begin
                tx_byte_d = ASCII_LF;
                tx_send   = 1'b1;
            end
            default: ;
        endcase
    end

    // Dump sequencer: each sending state advances only when its byte is loaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            ch_q    <= '0;
            nib_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SDU_DUMP_CKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        snap_q  <= ch_data;
                        busy_q  <= 1'b1;
                        ch_q    <= '0;
                        nib_q   <= '0;
`ifdef SDU_DUMP_CKSUM_EN
                        sum_q   <= '0;
`endif
                        state_q <= ST_SEND_HEX;
                    end
                end
                ST_SEND_HEX: begin
                    if (tx_load) begin
`ifdef SDU_DUMP_CKSUM_EN
                        sum_q <= sum_q + tx_byte_d;
`endif
                        if (nib_q == NIB_W'(NIB - 1)) begin
                            nib_q   <= '0;
                            state_q <= ST_SEND_SEP;
                        end else begin
                            nib_q <= nib_q + NIB_W'(1);
                        end
                    end
                end
                ST_SEND_SEP: begin
                    if (tx_load) begin
`ifdef SDU_DUMP_CKSUM_EN
                        sum_q <= sum_q + tx_byte_d;
`endif
                        // Counter is one bit wider than needed so it can end at NUM_CH.
                        ch_q <= ch_q + CH_W'(1);
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
`ifdef SDU_DUMP_CKSUM_EN
                            state_q <= ST_SEND_CK;
`else
                            state_q <= ST_SEND_CR;
`endif
                        end else begin
                            state_q <= ST_SEND_HEX;
                        end
                    end
                end
`ifdef SDU_DUMP_CKSUM_EN
                ST_SEND_CK: begin
                    if (tx_load) begin
                        if (nib_q == '0) begin
                            nib_q <= NIB_W'(1);
                        end else begin
                            nib_q   <= '0;
                            state_q <= ST_SEND_CR;
                        end
                    end
                end
`endif
                ST_SEND_CR: begin
                    if (tx_load) state_q <= ST_SEND_LF;
                end
                ST_SEND_LF: begin
                    if (tx_load) state_q <= ST_FIN;
                end
                ST_FIN: begin
                    // Wait for the LF stop bit to end, pulse done, then release busy.
                    if (done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (tx_ready) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_uart_tx_byte (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (tx_load),
        .data_i  (tx_byte_d),
        .ready_o (tx_ready),
        .txd_o   (txd)
    );

endmodule
